instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Instruction-fetch (IF) stage of the 5-stage MIPS pipeline, directly upstream of the IF/ID register. It holds the program counter and a word-organised instruction memory, and selects the next PC among sequential, jump and branch targets. It freezes on stall, detects the HALT opcode, and provides a byte-serial loader port through which the debug unit writes the program before execution. It presents `o_pc4` and `o_instruction`, which IF/ID captures on the falling edge of `i_clk`.

## Interface
- `NB`, 32, data/address width.
- `MEM_DEPTH`, 256, instruction memory depth in words.
- `NB_ADDR`, 8, word-address width (log2 of `MEM_DEPTH`).
- `HALT_OPCODE`, 32'hFFFF_FFFF, instruction word that stops fetch.

- `i_clk`  in  1  single clock; all state updates on rising edge.
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_step`  in  1  execution enable (continuous mode holds high, step mode pulses one cycle).
- `i_pc_write`  in  1  hazard-unit enable; 0 = stall, PC held.
- `i_branch_taken`  in  1  branch resolved taken.
- `i_branch_target`  in  NB  branch destination byte address.
- `i_jump`  in  1  jump request.
- `i_jump_target`  in  NB  jump destination byte address.
- `i_load_en`  in  1  loader byte valid.
- `i_load_data`  in  8  loader byte.
- `o_pc`  out  NB  current PC (byte address).
- `o_pc4`  out  NB  `o_pc + 4`, combinational.
- `o_instruction`  out  NB  memory word at `o_pc`, asynchronous read.
- `o_halt`  out  1  sticky; HALT fetched.
- `o_load_words`  out  NB_ADDR+1  number of complete words written by the loader.
- `o_mem_full`  out  1  `o_load_words == MEM_DEPTH`.

## Operation
- Memory is indexed by `o_pc[NB_ADDR+1:2]`. PC bits [1:0] are ignored. Higher bits wrap modulo `MEM_DEPTH`.
- Loader:
  - 2-bit byte counter and word pointer.
  - On each rising edge with `i_load_en=1` and `o_mem_full=0`, shift `i_load_data` into a 32-bit assembly register, big-endian (first byte = bits [31:24]).
  - On the 4th byte, write the assembled word at the word pointer, increment the pointer and `o_load_words`, and clear the byte counter.
  - Bytes arriving while `o_mem_full=1` are dropped. Counters are unchanged.
- Next-PC priority, highest first:
  - `i_branch_taken`: `i_branch_target`.
  - `i_jump`: `i_jump_target`.
  - Otherwise: `o_pc + 4`, wrapping at 2^NB.
- PC advance condition: `i_step & i_pc_write & ~o_halt & ~i_load_en`.
  - When any term is false, PC holds and all inputs are ignored.
  - `i_load_en` overrides execution: the load writes, the PC is frozen.
- HALT:
  - On a rising edge with `i_step=1` and `o_instruction == HALT_OPCODE`, set `o_halt <= 1`. The PC does not advance on that edge.
  - Once set, `o_halt` clears only on reset. Branch and jump requests are ignored while halted.
  - HALT detection is independent of `i_pc_write`: a stalled HALT still halts.
- Memory contents are not cleared by reset. A program survives reset and can be re-run.

## Timing
- Reset, asynchronous and immediate:
  - `o_pc=0`, `o_halt=0`, `o_load_words=0`, `o_mem_full=0`.
  - Byte counter 0, word pointer 0, assembly register 0.
  - `o_pc4=4`. `o_instruction` = mem[0] as currently stored.
- PC latency: 1 cycle. Redirect requests sampled at edge N take effect at `o_pc` after edge N.
- `o_instruction` and `o_pc4` settle combinationally within the high phase, ahead of the IF/ID falling-edge capture.
- Loader latency: the word is readable one edge after its 4th byte. `o_load_words` updates on the same edge.
- Reset mid-word, after 1–3 bytes: partial bytes are discarded and the next byte starts a new word at pointer 0.
- Simultaneous branch and jump: the branch wins.
- Simultaneous `i_load_en` and `i_step`: the load is performed, the PC holds, and HALT is not evaluated.

## Test plan
- Load bytes 20 08 00 05, FF FF FF FF -> `o_load_words=2`, mem[0]=32'h2008_0005, mem[1]=32'hFFFF_FFFF.
- After that load, reset, then `i_step=1` continuous -> `o_pc` 0→4, then holds at 4 with `o_halt=1` one edge after HALT is fetched; `o_pc4=8`.
- Running sequentially at PC=8: `i_pc_write=0` for 2 cycles -> PC stays 8, `o_instruction` stable. `i_branch_taken=1` with target 32'h40 and `i_jump=1` with target 32'h80 on the same edge -> PC=32'h40.
- `i_step` pulsed once every 3 cycles -> PC advances exactly one instruction per pulse. PC=4·(MEM_DEPTH−1) then a step -> PC=4·MEM_DEPTH, and `o_instruction`=mem[0] (wrap).
- Load 4·MEM_DEPTH+2 bytes -> `o_mem_full=1` and `o_load_words=256`; the 2 extra bytes leave mem[0] and mem[255] unchanged.
- Assert `i_reset` after 2 bytes of a word, then send 4 bytes AA BB CC DD -> mem[0]=32'hAABB_CCDD, `o_load_words=1`.

Source files
------------

// File: rtl/instruction_fetch.sv
// IF stage: program counter, word-organised instruction memory with a
// byte-serial loader, next-PC selection, stall freeze and sticky HALT detection.
module instruction_fetch #(
  parameter int unsigned   NB          = 32,
  parameter int unsigned   MEM_DEPTH   = 256,
  parameter int unsigned   NB_ADDR     = 8,
  parameter logic [NB-1:0] HALT_OPCODE = {NB{1'b1}}
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_step,
  input  logic               i_pc_write,
  input  logic               i_branch_taken,
  input  logic [NB-1:0]      i_branch_target,
  input  logic               i_jump,
  input  logic [NB-1:0]      i_jump_target,
  input  logic               i_load_en,
  input  logic [7:0]         i_load_data,
  output logic [NB-1:0]      o_pc,
  output logic [NB-1:0]      o_pc4,
  output logic [NB-1:0]      o_instruction,
  output logic               o_halt,
  output logic [NB_ADDR:0]   o_load_words,
  output logic               o_mem_full
);

  localparam int unsigned NB_BYTE = 8;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [NB-1:0]        pc;
  logic [NB-1:0]        pc_next;
  logic                 advance;
  logic [NB-1:0]        mem [MEM_DEPTH];
  logic [1:0]           byte_cnt;
  logic [NB_ADDR-1:0]   word_ptr;
  logic [NB-1:0]        asm_word;
  logic [NB-1:0]        word_next;
  logic [NB_ADDR:0]     load_words;
  logic                 load_ok;
  logic                 word_done;

  assign o_pc          = pc;
  assign o_pc4         = pc + NB'(4);
  assign o_instruction = mem[pc[NB_ADDR+1:2]];
  assign o_halt        = (state == ST_HALTED);
  assign o_load_words  = load_words;
  assign o_mem_full    = (load_words == (NB_ADDR+1)'(MEM_DEPTH));

  assign load_ok   = i_load_en & ~o_mem_full;
  assign word_done = load_ok & (byte_cnt == 2'd3);
  assign word_next = {asm_word[NB-NB_BYTE-1:0], i_load_data};

  // Run/halt control and next-PC selection; a pending load freezes execution
  always_comb begin
    state_next = state;
    advance    = 1'b0;
    pc_next    = o_pc4;
    if (i_branch_taken) begin
      pc_next = i_branch_target;
    end else if (i_jump) begin
      pc_next = i_jump_target;
    end
    case (state)
      ST_RUN: begin
        if (i_step && !i_load_en) begin
          if (o_instruction == HALT_OPCODE) begin
            state_next = ST_HALTED;
          end else if (i_pc_write) begin
            advance = 1'b1;
          end
        end
      end
      ST_HALTED: begin
        state_next = ST_HALTED;
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= ST_RUN;
      pc         <= '0;
      byte_cnt   <= 2'd0;
      word_ptr   <= '0;
      asm_word   <= '0;
      load_words <= '0;
    end else begin
      state <= state_next;
      if (advance) begin
        pc <= pc_next;
      end
      if (load_ok) begin
        asm_word <= word_next;
        if (byte_cnt == 2'd3) begin
          byte_cnt   <= 2'd0;
          word_ptr   <= word_ptr + NB_ADDR'(1);
          load_words <= load_words + (NB_ADDR+1)'(1);
        end else begin
          byte_cnt <= byte_cnt + 2'd1;
        end
      end
    end
  end

  // Program memory is deliberately not reset so a loaded program survives reset
  always_ff @(posedge i_clk) begin
    if (word_done && !i_reset) begin
      mem[word_ptr] <= word_next;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomised and directed bench for instruction_fetch against a behavioural
// model built from byte queues, a word array and a plain PC variable.
module tb_instruction_fetch;

  localparam int unsigned NB    = 32;
  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_step = 1'b0;
  logic        i_pc_write = 1'b1;
  logic        i_branch_taken = 1'b0;
  logic [31:0] i_branch_target = '0;
  logic        i_jump = 1'b0;
  logic [31:0] i_jump_target = '0;
  logic        i_load_en = 1'b0;
  logic [7:0]  i_load_data = '0;
  logic [31:0] o_pc;
  logic [31:0] o_pc4;
  logic [31:0] o_instruction;
  logic        o_halt;
  logic [8:0]  o_load_words;
  logic        o_mem_full;

  instruction_fetch dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_step          (i_step),
    .i_pc_write      (i_pc_write),
    .i_branch_taken  (i_branch_taken),
    .i_branch_target (i_branch_target),
    .i_jump          (i_jump),
    .i_jump_target   (i_jump_target),
    .i_load_en       (i_load_en),
    .i_load_data     (i_load_data),
    .o_pc            (o_pc),
    .o_pc4           (o_pc4),
    .o_instruction   (o_instruction),
    .o_halt          (o_halt),
    .o_load_words    (o_load_words),
    .o_mem_full      (o_mem_full)
  );

  always #5 i_clk = ~i_clk;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  // Reference model state
  logic [31:0] m_mem [DEPTH];
  bit          m_valid [DEPTH];
  logic [31:0] m_pc = '0;
  bit          m_halt = 1'b0;
  int unsigned m_words = 0;
  logic [7:0]  m_bytes [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned widx(input logic [31:0] pc);
    return int'(pc[9:2]);
  endfunction

  function automatic void model_reset();
    m_pc    = '0;
    m_halt  = 1'b0;
    m_words = 0;
    m_bytes.delete();
  endfunction

  // One rising edge of the model, using the inputs currently driven
  function automatic void model_edge();
    int unsigned i;
    i = widx(m_pc);
    if (i_load_en) begin
      if (m_words < DEPTH) begin
        m_bytes.push_back(i_load_data);
        if (m_bytes.size() == 4) begin
          m_mem[m_words]   = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
          m_valid[m_words] = 1'b1;
          m_words++;
          m_bytes.delete();
        end
      end
    end else if (i_step && !m_halt) begin
      if (m_valid[i] && m_mem[i] == HALT) begin
        m_halt = 1'b1;
      end else if (i_pc_write) begin
        if (i_branch_taken)  m_pc = i_branch_target;
        else if (i_jump)     m_pc = i_jump_target;
        else                 m_pc = m_pc + 32'd4;
      end
    end
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".pc"}, o_pc, m_pc);
    check({tag, ".pc4"}, o_pc4, m_pc + 32'd4);
    check({tag, ".halt"}, 32'(o_halt), 32'(m_halt));
    check({tag, ".words"}, 32'(o_load_words), m_words);
    check({tag, ".full"}, 32'(o_mem_full), 32'(m_words == DEPTH));
    if (m_valid[widx(m_pc)]) check({tag, ".instr"}, o_instruction, m_mem[widx(m_pc)]);
  endtask

  task automatic cycle(input string tag);
    model_edge();
    @(posedge i_clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    i_step = 1'b0; i_pc_write = 1'b1; i_branch_taken = 1'b0; i_jump = 1'b0;
    i_load_en = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    i_reset = 1'b1;
    #1;
    model_reset();
    check_all("reset");
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
  endtask

  task automatic load_byte(input logic [7:0] b);
    i_load_en = 1'b1;
    i_load_data = b;
    cycle("load");
    i_load_en = 1'b0;
  endtask

  task automatic load_word(input logic [31:0] w);
    logic [31:0] t;
    t = w;
    for (int k = 0; k < 4; k++) begin
      load_byte(t[31:24]);
      t = t << 8;
    end
  endtask

  logic [31:0] w;
  logic [31:0] held;

  initial begin
    for (int k = 0; k < int'(DEPTH); k++) m_valid[k] = 1'b0;
    @(posedge i_clk); #1;
    do_reset();

    // Two-word program, then run it to HALT
    load_word(32'h2008_0005);
    load_word(32'hFFFF_FFFF);
    check("plan.words2", 32'(o_load_words), 32'd2);
    check("plan.mem0", o_instruction, 32'h2008_0005);
    do_reset();
    i_step = 1'b1;
    cycle("run0");
    check("plan.pc4", o_pc, 32'd4);
    check("plan.mem1", o_instruction, 32'hFFFF_FFFF);
    cycle("run1");
    check("plan.halt", 32'(o_halt), 32'd1);
    check("plan.pc_hold", o_pc, 32'd4);
    cycle("run2");
    check("plan.pc4_8", o_pc4, 32'd8);

    // Reset in the middle of a word
    do_reset();
    load_byte(8'h11);
    load_byte(8'h22);
    do_reset();
    load_word(32'hAABB_CCDD);
    check("midrst.mem0", o_instruction, 32'hAABB_CCDD);
    check("midrst.words", 32'(o_load_words), 32'd1);

    // Fill the whole memory plus two dropped bytes
    do_reset();
    for (int k = 0; k < int'(DEPTH); k++) begin
      w = $urandom;
      if (w == HALT) w = 32'h0;
      load_word(w);
    end
    load_byte(8'hFF);
    load_byte(8'hFF);
    check("full.flag", 32'(o_mem_full), 32'd1);
    check("full.words", 32'(o_load_words), 32'd256);

    // Stall at PC=8, then branch beats jump
    do_reset();
    i_step = 1'b1;
    cycle("seq0");
    cycle("seq1");
    check("stall.pc8", o_pc, 32'd8);
    held = o_instruction;
    i_pc_write = 1'b0;
    cycle("stall0");
    cycle("stall1");
    check("stall.pc", o_pc, 32'd8);
    check("stall.instr", o_instruction, held);
    i_pc_write = 1'b1;
    i_branch_taken = 1'b1; i_branch_target = 32'h40;
    i_jump = 1'b1;         i_jump_target = 32'h80;
    cycle("brjmp");
    check("brjmp.pc", o_pc, 32'h40);
    i_branch_taken = 1'b0; i_jump = 1'b0;

    // Single-step pulses every third cycle
    for (int k = 0; k < 9; k++) begin
      i_step = (k % 3 == 0);
      cycle("pulse");
    end
    check("pulse.pc", o_pc, 32'h4C);

    // Wrap past the top of memory
    i_step = 1'b1;
    i_branch_taken = 1'b1; i_branch_target = 32'h3FC;
    cycle("wrap0");
    i_branch_taken = 1'b0;
    cycle("wrap1");
    check("wrap.pc", o_pc, 32'h400);

    // Load and step together: PC frozen, loader writes
    i_load_en = 1'b1; i_load_data = 8'h5A;
    cycle("ldstep");
    i_load_en = 1'b0;

    // Random execution with occasional loader bytes
    for (int k = 0; k < 400; k++) begin
      i_step          = ($urandom_range(0, 3) != 0);
      i_pc_write      = ($urandom_range(0, 4) != 0);
      i_branch_taken  = ($urandom_range(0, 6) == 0);
      i_branch_target = $urandom;
      i_jump          = ($urandom_range(0, 6) == 0);
      i_jump_target   = $urandom;
      i_load_en       = ($urandom_range(0, 19) == 0);
      i_load_data     = 8'($urandom);
      cycle("rand");
    end
    idle_inputs();

    // HALT detected while stalled; redirects ignored afterwards
    do_reset();
    i_step = 1'b1;
    load_word(32'hFFFF_FFFF);
    check("ldstep.nohalt", 32'(o_halt), 32'd0);
    i_pc_write = 1'b0;
    cycle("stallhalt");
    check("stallhalt.halt", 32'(o_halt), 32'd1);
    i_pc_write = 1'b1;
    i_branch_taken = 1'b1; i_branch_target = 32'h100;
    cycle("halted.br");
    check("halted.pc", o_pc, 32'd0);
    do_reset();
    check("rst.halt_clr", 32'(o_halt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
